multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 32 +++
 rtl/multicycle_control.sv | 147 ++++++++++++++
 tb/tb_multicycle_control.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle controller.
// The master modport is the controller side. The slave modport is the datapath/memory side.
interface multicycle_control_if;
    logic [15:0] instr;
    logic        mem_ready;
    logic        zero;
    logic [1:0]  ALUOp;
    logic [3:0]  opcode;
    logic [1:0]  Funct;
    logic        pc_write;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [1:0]  alu_src_b;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic        halted;

    modport master (
        input  instr, mem_ready, zero,
        output ALUOp, opcode, Funct, pc_write, ir_write, mem_read, mem_write,
               reg_write, mem_to_reg, alu_src_b, pc_src, state, halted
    );

    modport slave (
        output instr, mem_ready, zero,
        input  ALUOp, opcode, Funct, pc_write, ir_write, mem_read, mem_write,
               reg_write, mem_to_reg, alu_src_b, pc_src, state, halted
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with a memory-ready handshake in FETCH and MEM.
// Optional macro ILLEGAL_TRAP_EN sends illegal opcodes to TRAP. Without it, illegal opcodes act as NOPs.
module multicycle_control (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_if.master        bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_ANDI  = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t      r_state, w_next_state;
    logic [3:0]  r_opcode;
    logic [1:0]  r_funct;
    logic [1:0]  w_alu_op, w_alu_src_b, w_pc_src;
    logic        w_pc_write, w_ir_write, w_mem_read, w_mem_write;
    logic        w_reg_write, w_mem_to_reg, w_halted;
    logic        w_unused;

    // Operand fields of the instruction are consumed by the datapath, not here.
    assign w_unused = ^bus.instr[11:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_opcode <= 4'h0;
            r_funct  <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if (w_ir_write) begin
                r_opcode <= bus.instr[15:12];
                r_funct  <= bus.instr[1:0];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_alu_op     = 2'b00;
        w_alu_src_b  = 2'b00;
        w_pc_src     = 2'b00;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_halted     = 1'b0;
        unique case (r_state)
            S_IDLE: w_next_state = S_FETCH;
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                case (r_opcode)
                    OP_JMP: begin
                        w_pc_write   = 1'b1;
                        w_pc_src     = 2'b10;
                        w_next_state = S_FETCH;
                    end
                    OP_HALT: w_next_state = S_HALT;
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_ANDI:
                        w_next_state = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
                    default: w_next_state = S_TRAP;
`else
                    default: w_next_state = S_FETCH;
`endif
                endcase
            end
            S_EXEC: begin
                w_next_state = S_WB;
                case (r_opcode)
                    OP_RTYPE: w_alu_op = 2'b10;
                    OP_ADDI:  w_alu_src_b = 2'b10;
                    OP_LW, OP_SW: begin
                        w_alu_src_b  = 2'b10;
                        w_next_state = S_MEM;
                    end
                    OP_ANDI: begin
                        w_alu_op    = 2'b11;
                        w_alu_src_b = 2'b10;
                    end
                    OP_BEQ: begin
                        w_alu_op     = 2'b01;
                        w_pc_src     = 2'b01;
                        w_pc_write   = bus.zero;
                        w_next_state = S_FETCH;
                    end
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                // Strobe stays up for the whole access; only mem_ready ends it.
                w_mem_read  = (r_opcode == OP_LW);
                w_mem_write = (r_opcode == OP_SW);
                if (bus.mem_ready)
                    w_next_state = (r_opcode == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (r_opcode == OP_LW);
                w_next_state = S_FETCH;
            end
            S_HALT: w_halted = 1'b1;
            S_TRAP: w_halted = 1'b1;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign bus.ALUOp      = w_alu_op;
    assign bus.opcode     = r_opcode;
    assign bus.Funct      = r_funct;
    assign bus.pc_write   = w_pc_write;
    assign bus.ir_write   = w_ir_write;
    assign bus.mem_read   = w_mem_read;
    assign bus.mem_write  = w_mem_write;
    assign bus.reg_write  = w_reg_write;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.pc_src     = w_pc_src;
    assign bus.state      = r_state;
    assign bus.halted     = w_halted;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction walks, memory stalls, branch, halt/trap, mid-access reset.
module tb_multicycle_control;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes0(input string tag);
        chk({tag, "_strobes"}, {10'd0, bus.pc_write, bus.ir_write, bus.mem_read,
                                bus.mem_write, bus.reg_write, bus.mem_to_reg}, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_state", {13'd0, bus.state}, 16'd0);
        chk("rst_opcode", {12'd0, bus.opcode}, 16'd0);
        chk("rst_halted", {15'd0, bus.halted}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks      = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.instr     = 16'h0000;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_state", {13'd0, bus.state}, 16'd0);
        chk("reset_opcode", {12'd0, bus.opcode}, 16'd0);
        chk("reset_funct", {14'd0, bus.Funct}, 16'd0);
        chk("reset_selects", {10'd0, bus.ALUOp, bus.alu_src_b, bus.pc_src}, 16'd0);
        chk("reset_halted", {15'd0, bus.halted}, 16'd0);
        strobes0("reset");

        // R-type: IDLE, FETCH, DECODE, EXEC, WB, FETCH
        @(negedge clk);
        rst_n = 1'b1; bus.instr = 16'h0005; bus.mem_ready = 1'b1;
        #1;
        chk("r_idle", {13'd0, bus.state}, 16'd0);
        tick();
        chk("r_fetch", {13'd0, bus.state}, 16'd1);
        chk("r_fetch_strb", {12'd0, bus.mem_read, bus.ir_write, bus.pc_write, 1'b0}, 16'hE);
        chk("r_fetch_srcb", {14'd0, bus.alu_src_b}, 16'd1);
        tick();
        chk("r_decode", {13'd0, bus.state}, 16'd2);
        chk("r_decode_srcb", {14'd0, bus.alu_src_b}, 16'd3);
        tick();
        chk("r_exec", {13'd0, bus.state}, 16'd3);
        chk("r_exec_aluop", {14'd0, bus.ALUOp}, 16'd2);
        chk("r_exec_funct", {14'd0, bus.Funct}, 16'd1);
        chk("r_exec_srcb", {14'd0, bus.alu_src_b}, 16'd0);
        tick();
        chk("r_wb", {13'd0, bus.state}, 16'd5);
        chk("r_wb_regw", {14'd0, bus.reg_write, bus.mem_to_reg}, 16'h2);
        tick();
        chk("r_fetch2", {13'd0, bus.state}, 16'd1);

        // LW with three stall cycles in MEM
        bus.instr = 16'h2ABC;
        tick();
        chk("lw_decode_op", {12'd0, bus.opcode}, 16'd2);
        tick();
        chk("lw_exec", {12'd0, bus.ALUOp, bus.alu_src_b}, 16'h2);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lw_mem_stall", {12'd0, bus.state, bus.mem_read}, 16'h9);
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("lw_mem_last", {12'd0, bus.state, bus.mem_read}, 16'h9);
        tick();
        chk("lw_wb", {13'd0, bus.state}, 16'd5);
        chk("lw_wb_m2r", {14'd0, bus.reg_write, bus.mem_to_reg}, 16'h3);
        tick();

        // FETCH stall must not latch the new opcode
        bus.instr = 16'h4000; bus.mem_ready = 1'b0;
        #1;
        chk("fetch_stall_irw", {15'd0, bus.ir_write}, 16'd0);
        tick();
        chk("fetch_stall_state", {13'd0, bus.state}, 16'd1);
        chk("fetch_stall_op", {12'd0, bus.opcode}, 16'd2);
        bus.mem_ready = 1'b1;
        #1;
        chk("fetch_ready_irw", {15'd0, bus.ir_write}, 16'd1);

        // BEQ taken then not taken
        tick();
        tick();
        bus.zero = 1'b1;
        #1;
        chk("beq_taken", {11'd0, bus.pc_write, bus.pc_src, bus.ALUOp}, 16'h15);
        tick();
        chk("beq_back_fetch", {13'd0, bus.state}, 16'd1);
        tick();
        tick();
        bus.zero = 1'b0;
        #1;
        chk("beq_not_taken", {11'd0, bus.pc_write, bus.pc_src, bus.ALUOp}, 16'h05);
        tick();

        // Illegal opcode
        bus.instr = 16'h8000;
        tick();
        chk("ill_decode_op", {12'd0, bus.opcode}, 16'h8);
        strobes0("ill_decode");
        tick();
`ifdef ILLEGAL_TRAP_EN
        chk("ill_trap", {12'd0, bus.state, bus.halted}, 16'hF);
        tick();
        tick();
        chk("ill_trap_hold", {12'd0, bus.state, bus.halted}, 16'hF);
        strobes0("ill_trap");
`else
        chk("ill_nop_fetch", {12'd0, bus.state, bus.halted}, 16'h2);
        chk("ill_nop_writes", {14'd0, bus.reg_write, bus.mem_write}, 16'd0);
`endif
        do_reset();

        // HALT
        bus.instr = 16'hF000;
        tick();
        tick();
        tick();
        chk("halt_state", {12'd0, bus.state, bus.halted}, 16'hD);
        tick();
        tick();
        chk("halt_hold", {12'd0, bus.state, bus.halted}, 16'hD);
        strobes0("halt");
        do_reset();

        // SW interrupted by reset mid-MEM
        bus.instr = 16'h3001;
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
        chk("sw_mem", {12'd0, bus.state, bus.mem_write}, 16'h9);
        tick();
        chk("sw_mem_hold", {12'd0, bus.state, bus.mem_write}, 16'h9);
        #3;
        rst_n = 1'b0;
        #1;
        chk("sw_rst_state", {13'd0, bus.state}, 16'd0);
        chk("sw_rst_memw", {15'd0, bus.mem_write}, 16'd0);
        chk("sw_rst_opfn", {10'd0, bus.opcode, bus.Funct}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1; bus.mem_ready = 1'b1;

        // JMP then ANDI
        bus.instr = 16'h5000;
        tick();
        tick();
        chk("jmp_decode", {12'd0, bus.pc_write, bus.pc_src, 1'b0}, 16'hC);
        bus.instr = 16'h6003;
        tick();
        chk("jmp_fetch", {13'd0, bus.state}, 16'd1);
        tick();
        tick();
        chk("andi_exec", {12'd0, bus.ALUOp, bus.alu_src_b}, 16'hE);
        tick();
        chk("andi_wb", {13'd0, bus.state, bus.reg_write, bus.mem_to_reg}, 16'h16);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
